pico_exec_ctrl: RTL and testbench
=================================

// Module: pico_exec_ctrl
// PURPOSE
//  Execute/control slice of the pico single-cycle core: instruction decoder, N-bit ALU and
//  external-interrupt edge detector in one block. Sits between register file/ROM and the PC.
//  Consumes the opcode and operands of the current instruction. Produces the ALU result,
//  flags, RF write controls, PC mode, and halt/wait-for-interrupt (WFI) status.
//  Only state: interrupt synchronizer, edge detector and pending-interrupt latch.
// PARAMETERS
//  N         8  datapath width (operands, immediate, result)
//  W_OPCODE  4  opcode width
// PORTS
//  clk_i       in   1         clock; all state updates on rising edge
//  rst_i       in   1         reset, asynchronous, active-high
//  op_code_i   in   W_OPCODE  opcode of current instruction
//  rd_data_i   in   N         RF rd operand (signed)
//  rs_data_i   in   N         RF rs operand (signed)
//  imm_i       in   N         signed immediate / branch offset
//  ext_int_i   in   1         asynchronous external interrupt request, level
//  result_o    out  N         ALU result; RF write data
//  flags_o     out  4         {V,C,N,Z} of result_o
//  wr_en_rf_o  out  1         write rd this cycle
//  wr_ext_o    out  1         RF write source is external data, not result_o
//  mode_pc_o   out  2         0=INC (pc+1), 1=BRANCH (pc+imm_i), 2=HOLD
//  halt_o      out  1         core halted
//  wfi_o       out  1         core waiting for interrupt
// BEHAVIOUR
//  Decode and ALU are purely combinational, zero latency. All outputs valid in the cycle op_code_i is presented.
//  ALU operands: A = imm_i for ADDI/LDI, else rd_data_i; B = rs_data_i.
//  ALU ops: ADD A+B; SUB A-B; AND; OR; XOR.
//   SHL: A<<B[$clog2(N)-1:0]. SRA: arithmetic A>>>B[$clog2(N)-1:0]. PASSA: A.
//  Results wrap modulo 2^N.
//  Flags: Z=(result==0); N=result[N-1].
//   C = carry-out for ADD; borrow (A<B unsigned) for SUB; 0 otherwise.
//   V = signed overflow for ADD/SUB; 0 otherwise.
//  Opcodes (write = wr_en_rf_o=1; mode = INC unless stated):
//   0 NOP: no write.  1 ADD  2 SUB  3 AND  4 OR  5 XOR  6 SHL  7 SRA: rd<=rd op rs.
//   8 ADDI: rd<=imm+rs.  9 LDI: rd<=imm (PASSA).
//   10 IN: wr_en_rf_o=1, wr_ext_o=1.
//   11 BEQ: ALU SUB rd-rs, no write; mode BRANCH if Z, else INC.
//   12 BLT: ALU SUB, no write; mode BRANCH if N^V (signed rd<rs), else INC.
//   13 JMP: no write, mode BRANCH.
//   14 WFI: no write. If wake=pending|edge then wfi_o=0, mode INC; else wfi_o=1, mode HOLD.
//   15 HALT: halt_o=1, mode HOLD, no write; stays halted while opcode presented.
//  wr_ext_o=0 and halt_o=0 for all opcodes except as stated above.
//  Interrupt synchronizer/edge detector:
//   s1<=ext_int_i, s2<=s1, s3<=s2 each clock.
//   edge = s2 & ~s3.
//   ext_int_i rise sampled at clock edge E0 gives edge high exactly one cycle, between E1 and E2.
//   Held level produces no further edges. Falling edges ignored.
//  pending: set on clock when edge=1 and not consumed. Cleared on clock when WFI executes with wake=1.
//   Simultaneous edge and WFI: wake in same cycle, pending stays 0.
//   Edge during HALT or other opcodes: latched; wakes the next WFI at once.
//  Reset (async assert, sync-safe release): s1,s2,s3,pending = 0.
//   Outputs remain combinational; with op_code_i=0, outputs are mode INC, no write, halt_o=0, wfi_o=0.
//  Reset during WFI drops pending; a later edge is required to wake.
// TESTING
//  ADD rd=0x7F rs=0x01 -> result 0x80, V=1, N=1, C=0, Z=0, wr_en_rf_o=1, mode INC.
//  SUB rd=0x05 rs=0x05 -> result 0x00, Z=1, C=0. SUB rd=0x00 rs=0x01 -> 0xFF, C=1, N=1.
//  BEQ rd=rs=0x22 imm=-3 -> mode BRANCH, wr_en_rf_o=0. Same with rs=0x23 -> mode INC.
//   BLT rd=0xFE rs=0x01 -> BRANCH.
//  ADDI imm=0xFC rs=0x06 -> result 0x02, C=1. LDI imm=0x9A -> 0x9A.
//   SRA rd=0x80 rs=0x03 -> 0xF0.
//   IN -> wr_en_rf_o=1, wr_ext_o=1.
//  WFI held, ext_int_i 0->1 at E0 -> wfi_o=1/mode HOLD until after E1.
//   wfi_o=0/mode INC in cycle E1-E2. ext_int_i held high: no second wake.
//  ext_int_i pulse during NOP, WFI three cycles later -> immediate wake; next WFI holds.
//   HALT -> halt_o=1, mode HOLD. rst_i mid-pending clears pending.

Source files
------------

// File: rtl/pico_exec_ctrl.sv
// Execute/control slice of the pico core: combinational decoder and ALU,
// plus a three-flop interrupt synchronizer, rising-edge detector and pending-wake latch.
module pico_exec_ctrl #(
    parameter int N        = 8,
    parameter int W_OPCODE = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [W_OPCODE-1:0] op_code_i,
    input  logic [N-1:0]        rd_data_i,
    input  logic [N-1:0]        rs_data_i,
    input  logic [N-1:0]        imm_i,
    input  logic                ext_int_i,
    output logic [N-1:0]        result_o,
    output logic [3:0]          flags_o,
    output logic                wr_en_rf_o,
    output logic                wr_ext_o,
    output logic [1:0]          mode_pc_o,
    output logic                halt_o,
    output logic                wfi_o
);
    localparam int SHW = $clog2(N);

    localparam logic [W_OPCODE-1:0] OP_ADD  = W_OPCODE'(1);
    localparam logic [W_OPCODE-1:0] OP_SUB  = W_OPCODE'(2);
    localparam logic [W_OPCODE-1:0] OP_AND  = W_OPCODE'(3);
    localparam logic [W_OPCODE-1:0] OP_OR   = W_OPCODE'(4);
    localparam logic [W_OPCODE-1:0] OP_XOR  = W_OPCODE'(5);
    localparam logic [W_OPCODE-1:0] OP_SHL  = W_OPCODE'(6);
    localparam logic [W_OPCODE-1:0] OP_SRA  = W_OPCODE'(7);
    localparam logic [W_OPCODE-1:0] OP_ADDI = W_OPCODE'(8);
    localparam logic [W_OPCODE-1:0] OP_LDI  = W_OPCODE'(9);
    localparam logic [W_OPCODE-1:0] OP_IN   = W_OPCODE'(10);
    localparam logic [W_OPCODE-1:0] OP_BEQ  = W_OPCODE'(11);
    localparam logic [W_OPCODE-1:0] OP_BLT  = W_OPCODE'(12);
    localparam logic [W_OPCODE-1:0] OP_JMP  = W_OPCODE'(13);
    localparam logic [W_OPCODE-1:0] OP_WFI  = W_OPCODE'(14);
    localparam logic [W_OPCODE-1:0] OP_HALT = W_OPCODE'(15);

    localparam logic [1:0] PC_INC    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_HOLD   = 2'd2;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_XOR   = 3'd4;
    localparam logic [2:0] ALU_SHL   = 3'd5;
    localparam logic [2:0] ALU_SRA   = 3'd6;
    localparam logic [2:0] ALU_PASSA = 3'd7;

    logic [2:0] sync_q, sync_d;
    logic       pending_q, pending_d;
    logic       int_edge;
    logic       wake;

    logic [2:0]   alu_op;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic [N:0]   wide;
    logic [N-1:0] res;
    logic         flag_c;
    logic         flag_v;

    // s2 high while s3 still low marks exactly one cycle after a sampled rise.
    assign int_edge = sync_q[1] & ~sync_q[2];
    assign wake     = pending_q | int_edge;

    always_comb begin
        alu_op     = ALU_PASSA;
        wr_en_rf_o = 1'b0;
        wr_ext_o   = 1'b0;
        mode_pc_o  = PC_INC;
        halt_o     = 1'b0;
        wfi_o      = 1'b0;
        case (op_code_i)
            OP_ADD:  begin alu_op = ALU_ADD; wr_en_rf_o = 1'b1; end
            OP_SUB:  begin alu_op = ALU_SUB; wr_en_rf_o = 1'b1; end
            OP_AND:  begin alu_op = ALU_AND; wr_en_rf_o = 1'b1; end
            OP_OR:   begin alu_op = ALU_OR;  wr_en_rf_o = 1'b1; end
            OP_XOR:  begin alu_op = ALU_XOR; wr_en_rf_o = 1'b1; end
            OP_SHL:  begin alu_op = ALU_SHL; wr_en_rf_o = 1'b1; end
            OP_SRA:  begin alu_op = ALU_SRA; wr_en_rf_o = 1'b1; end
            OP_ADDI: begin alu_op = ALU_ADD; wr_en_rf_o = 1'b1; end
            OP_LDI:  wr_en_rf_o = 1'b1;
            OP_IN:   begin wr_en_rf_o = 1'b1; wr_ext_o = 1'b1; end
            OP_BEQ:  alu_op = ALU_SUB;
            OP_BLT:  alu_op = ALU_SUB;
            OP_JMP:  mode_pc_o = PC_BRANCH;
            OP_WFI:  begin
                wfi_o     = ~wake;
                mode_pc_o = wake ? PC_INC : PC_HOLD;
            end
            OP_HALT: begin halt_o = 1'b1; mode_pc_o = PC_HOLD; end
            default: ;
        endcase
        // Branch decisions depend on the ALU flags computed below.
        if (op_code_i == OP_BEQ && res == '0)
            mode_pc_o = PC_BRANCH;
        if (op_code_i == OP_BLT && (res[N-1] ^ flag_v))
            mode_pc_o = PC_BRANCH;
    end

    assign op_a = (op_code_i == OP_ADDI || op_code_i == OP_LDI) ? imm_i : rd_data_i;
    assign op_b = rs_data_i;

    always_comb begin
        wide   = '0;
        res    = op_a;
        flag_c = 1'b0;
        flag_v = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                wide   = {1'b0, op_a} + {1'b0, op_b};
                res    = wide[N-1:0];
                flag_c = wide[N];
                flag_v = (op_a[N-1] == op_b[N-1]) && (res[N-1] != op_a[N-1]);
            end
            ALU_SUB: begin
                wide   = {1'b0, op_a} - {1'b0, op_b};
                res    = wide[N-1:0];
                flag_c = wide[N];
                flag_v = (op_a[N-1] != op_b[N-1]) && (res[N-1] != op_a[N-1]);
            end
            ALU_AND: res = op_a & op_b;
            ALU_OR:  res = op_a | op_b;
            ALU_XOR: res = op_a ^ op_b;
            ALU_SHL: res = op_a << op_b[SHW-1:0];
            ALU_SRA: res = $signed(op_a) >>> op_b[SHW-1:0];
            default: res = op_a;
        endcase
    end

    assign result_o = res;
    assign flags_o  = {flag_v, flag_c, res[N-1], (res == '0)};

    always_comb begin
        sync_d    = {sync_q[1:0], ext_int_i};
        pending_d = pending_q;
        // A waking WFI consumes both a latched request and a same-cycle edge.
        if (op_code_i == OP_WFI && wake)
            pending_d = 1'b0;
        else if (int_edge)
            pending_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: tb/tb_pico_exec_ctrl.sv
// Bench for pico_exec_ctrl: directed cases plus random traffic, checked by a
// negedge monitor against expectations queued by the driver from a reference model.
module tb_pico_exec_ctrl;
  localparam int N = 8;
  localparam int EW = 19;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [3:0]   op_code_i = '0;
  logic [N-1:0] rd_data_i = '0;
  logic [N-1:0] rs_data_i = '0;
  logic [N-1:0] imm_i = '0;
  logic         ext_int_i = 1'b0;
  logic [N-1:0] result_o;
  logic [3:0]   flags_o;
  logic         wr_en_rf_o;
  logic         wr_ext_o;
  logic [1:0]   mode_pc_o;
  logic         halt_o;
  logic         wfi_o;

  pico_exec_ctrl #(.N(N), .W_OPCODE(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .op_code_i(op_code_i), .rd_data_i(rd_data_i),
    .rs_data_i(rs_data_i), .imm_i(imm_i), .ext_int_i(ext_int_i), .result_o(result_o),
    .flags_o(flags_o), .wr_en_rf_o(wr_en_rf_o), .wr_ext_o(wr_ext_o), .mode_pc_o(mode_pc_o),
    .halt_o(halt_o), .wfi_o(wfi_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // scoreboard: {check_alu, result[7:0], flags{V,C,N,Z}, wr_en, wr_ext, mode[1:0], halt, wfi}
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // reference model state: history of sampled ext_int_i levels and the wake latch
  bit       hist[$];
  bit       m_pending = 1'b0;
  bit       in_rst = 1'b1;
  bit [3:0] last_op = '0;
  bit       last_wake = 1'b0;
  bit       last_edge = 1'b0;

  function automatic logic [EW-1:0] model(input logic [3:0] op, input logic [7:0] rd,
                                          input logic [7:0] rs, input logic [7:0] imm,
                                          input bit wake);
    logic [7:0] av, bv, r;
    int ua, ub, sa, sb, full, sv;
    bit c, v, chk, we, wx, halt, wfi;
    logic [1:0] mode;
    av = (op == 4'd8 || op == 4'd9) ? imm : rd;
    bv = rs;
    ua = av; ub = bv;
    sa = $signed(av); sb = $signed(bv);
    r = av; c = 0; v = 0; chk = 1; we = 0; wx = 0; halt = 0; wfi = 0; mode = 2'd0;
    case (op)
      4'd1, 4'd8: begin
        full = ua + ub; r = full[7:0]; c = (full > 255);
        sv = sa + sb; v = (sv > 127 || sv < -128); we = 1;
      end
      4'd2, 4'd11, 4'd12: begin
        full = ua - ub; r = full[7:0]; c = (ua < ub);
        sv = sa - sb; v = (sv > 127 || sv < -128);
        we = (op == 4'd2);
        if (op == 4'd11 && ua == ub) mode = 2'd1;
        if (op == 4'd12 && sa < sb) mode = 2'd1;
      end
      4'd3: begin r = av & bv; we = 1; end
      4'd4: begin r = av | bv; we = 1; end
      4'd5: begin r = av ^ bv; we = 1; end
      4'd6: begin full = ua * (1 << (ub % 8)); r = full[7:0]; we = 1; end
      4'd7: begin sv = sa >>> (ub % 8); r = sv[7:0]; we = 1; end
      4'd9: begin r = av; we = 1; end
      4'd10: begin chk = 0; we = 1; wx = 1; end
      4'd13: begin chk = 0; mode = 2'd1; end
      4'd14: begin chk = 0; wfi = !wake; mode = wake ? 2'd0 : 2'd2; end
      4'd15: begin chk = 0; halt = 1; mode = 2'd2; end
      default: chk = 0;
    endcase
    return {chk, r, v, c, r[7], (r == 8'h00), we, wx, mode, halt, wfi};
  endfunction

  // driver: one instruction per cycle, inputs change 1 time unit after the rising edge
  task automatic step(input logic [3:0] op, input logic [7:0] rd, input logic [7:0] rs,
                      input logic [7:0] imm, input bit ext, input bit rst_v);
    bit edge_now, wake;
    @(posedge clk_i);
    if (in_rst) begin
      hist.push_back(1'b0);
    end else begin
      if (last_op == 4'd14 && last_wake) m_pending = 1'b0;
      else if (last_edge) m_pending = 1'b1;
      hist.push_back(ext_int_i);
    end
    while (hist.size() > 4) void'(hist.pop_front());
    #1;
    op_code_i = op; rd_data_i = rd; rs_data_i = rs; imm_i = imm;
    ext_int_i = ext; rst_i = rst_v;
    in_rst = rst_v;
    if (rst_v) begin
      m_pending = 1'b0;
      foreach (hist[i]) hist[i] = 1'b0;
    end
    // a rise shows up as an edge one sample after it was first captured
    edge_now = hist[hist.size()-2] && !hist[hist.size()-3];
    wake = m_pending | edge_now;
    exp_q.push_back(model(op, rd, rs, imm, wake));
    last_op = op; last_wake = wake; last_edge = edge_now;
  endtask

  task automatic nop_n(input int n, input bit ext);
    for (int i = 0; i < n; i++) step(4'd0, 8'h00, 8'h00, 8'h00, ext, 1'b0);
  endtask

  task automatic wfi_n(input int n, input bit ext);
    for (int i = 0; i < n; i++) step(4'd14, 8'h00, 8'h00, 8'h00, ext, 1'b0);
  endtask

  // monitor
  always @(negedge clk_i) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({wr_en_rf_o, wr_ext_o, mode_pc_o, halt_o, wfi_o} !== e[5:0]) begin
        errors++;
        $display("FAIL ctrl t=%0t op=%0d got we/wx/mode/halt/wfi=%b/%b/%0d/%b/%b exp=%b/%b/%0d/%b/%b",
                 $time, op_code_i, wr_en_rf_o, wr_ext_o, mode_pc_o, halt_o, wfi_o,
                 e[5], e[4], e[3:2], e[1], e[0]);
      end
      if (e[18]) begin
        checks++;
        if ({result_o, flags_o} !== e[17:6]) begin
          errors++;
          $display("FAIL alu t=%0t op=%0d rd=%h rs=%h imm=%h got res=%h flags=%b exp res=%h flags=%b",
                   $time, op_code_i, rd_data_i, rs_data_i, imm_i, result_o, flags_o,
                   e[17:10], e[9:6]);
        end
      end
    end
  end

  initial begin
    hist = '{1'b0, 1'b0, 1'b0};
    step(4'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    step(4'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    nop_n(2, 1'b0);

    // directed ALU / decode cases
    step(4'd1,  8'h7F, 8'h01, 8'h00, 1'b0, 1'b0);
    step(4'd2,  8'h05, 8'h05, 8'h00, 1'b0, 1'b0);
    step(4'd2,  8'h00, 8'h01, 8'h00, 1'b0, 1'b0);
    step(4'd11, 8'h22, 8'h22, 8'hFD, 1'b0, 1'b0);
    step(4'd11, 8'h22, 8'h23, 8'hFD, 1'b0, 1'b0);
    step(4'd12, 8'hFE, 8'h01, 8'h10, 1'b0, 1'b0);
    step(4'd12, 8'h01, 8'hFE, 8'h10, 1'b0, 1'b0);
    step(4'd8,  8'h33, 8'h06, 8'hFC, 1'b0, 1'b0);
    step(4'd9,  8'h11, 8'h22, 8'h9A, 1'b0, 1'b0);
    step(4'd7,  8'h80, 8'h03, 8'h00, 1'b0, 1'b0);
    step(4'd6,  8'h81, 8'h0B, 8'h00, 1'b0, 1'b0);
    step(4'd10, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    step(4'd13, 8'h00, 8'h00, 8'h05, 1'b0, 1'b0);
    step(4'd15, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    step(4'd15, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

    // WFI held while the interrupt rises, then stays high
    wfi_n(3, 1'b0);
    wfi_n(6, 1'b1);
    wfi_n(3, 1'b0);

    // one-cycle pulse during NOP, WFI three cycles later wakes at once, the next holds
    nop_n(1, 1'b1);
    nop_n(2, 1'b0);
    wfi_n(3, 1'b0);

    // pulse latched during HALT
    step(4'd15, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    step(4'd15, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    step(4'd15, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    wfi_n(2, 1'b0);

    // reset while a request is pending drops it
    nop_n(1, 1'b1);
    nop_n(3, 1'b0);
    step(4'd14, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    step(4'd14, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    wfi_n(4, 1'b0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [3:0] op;
      bit ext, rv;
      op = 4'($urandom_range(0, 15));
      ext = ext_int_i;
      if ($urandom_range(0, 5) == 0) ext = !ext;
      rv = ($urandom_range(0, 59) == 0);
      step(op, 8'($urandom), 8'($urandom), 8'($urandom), ext, rv);
    end

    @(negedge clk_i);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expectations exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
